// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for the sequential divider.
// The controller drives through the master modport; the divider sits on slave.
interface seq_divider_if #(
    parameter int N = 16
);
    logic             start;
    logic [N-1:0]     dividend;
    logic [N/2-1:0]   divisor;
    logic             busy;
    logic             done;
    logic [N/2-1:0]   quotient;
    logic [N/2-1:0]   remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: N-bit dividend / N/2-bit divisor, one quotient bit per clock.
// A single N-bit working register holds the partial remainder (high half) and the dividend/quotient (low half).
module seq_divider #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         clear,
    seq_divider_if.slave dif
);
    localparam int H  = N / 2;
    localparam int CW = $clog2(H + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    w_q, w_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [H-1:0]    div_q, div_d;
    logic [H-1:0]    quot_q, quot_d;
    logic [H-1:0]    rem_q, rem_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;
    logic [N-1:0]    w_next;

    // The trial value is H+1 bits wide so the bit shifted out of the remainder is never lost.
    function automatic logic [N-1:0] restore_step(input logic [N-1:0] w, input logic [H-1:0] d);
        logic [H:0] t;
        logic [H:0] diff;
        logic       ge;
        t    = {w[N-1:H], w[H-1]};
        ge   = (t >= {1'b0, d});
        diff = t - {1'b0, d};
        restore_step = {(ge ? diff[H-1:0] : t[H-1:0]), w[H-2:0], ge};
    endfunction

    assign w_next = restore_step(w_q, div_q);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (dif.start) begin
                    div_d = dif.divisor;
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (dif.divisor == '0) begin
                        dbz_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                        state_d = DONE;
                    end else if (dif.dividend[N-1:H] >= dif.divisor) begin
                        ovf_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        w_d     = dif.dividend;
                        cnt_d   = CW'(H);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                w_d   = w_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = w_next[H-1:0];
                    rem_d   = w_next[N-1:H];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dif.busy        = (state_q != IDLE);
    assign dif.done        = (state_q == DONE);
    assign dif.quotient    = quot_q;
    assign dif.remainder   = rem_q;
    assign dif.div_by_zero = dbz_q;
    assign dif.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=16): directed operands with hand-computed results.
module tb_seq_divider;
    logic clk;
    logic clear;

    seq_divider_if #(.N(16)) dif ();

    seq_divider #(.N(16)) dut (
        .clk   (clk),
        .clear (clear),
        .dif   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         lat;
        int         c0;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one start pulse; optionally record the expected completion.
    task automatic issue(input logic [15:0] dvd, input logic [7:0] dvs, input bit push,
                         input logic [7:0] q, input logic [7:0] r,
                         input logic dbz, input logic ovf, input int lat);
        exp_t e;
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = dvd;
        dif.divisor  = dvs;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        if (push) begin
            e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.lat = lat; e.c0 = cyc;
            sbq.push_back(e);
        end
    endtask

    // Wait for done (bounded); exp_busy < 0 skips the busy-length check.
    task automatic wait_done(input int exp_busy);
        int  n_busy;
        bit  seen;
        n_busy = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dif.busy === 1'b1) n_busy++;
            if (dif.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done, expected done within 40 cycles");
        end
        @(negedge clk);
        chk("busy_after_done", dif.busy, 0);
        if (exp_busy >= 0) chk("busy_cycles", n_busy, exp_busy);
    endtask

    task automatic run(input logic [15:0] dvd, input logic [7:0] dvs,
                       input logic [7:0] q, input logic [7:0] r,
                       input logic dbz, input logic ovf, input int lat);
        issue(dvd, dvs, 1'b1, q, r, dbz, ovf, lat);
        wait_done(lat + 1);
    endtask

    initial begin
        int   seen_busy;
        int   seen_done;
        int   dc;
        clear        = 1'b1;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (dif.done === 1'b1) begin
                    done_cnt++;
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: got done, expected none (q=%0h r=%0h)",
                                 dif.quotient, dif.remainder);
                    end else begin
                        e = sbq.pop_front();
                        chk("quotient", dif.quotient, e.q);
                        chk("remainder", dif.remainder, e.r);
                        chk("div_by_zero", dif.div_by_zero, e.dbz);
                        chk("overflow", dif.overflow, e.ovf);
                        chk("latency", cyc - e.c0, e.lat);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", dif.busy, 0);
        chk("rst_done", dif.done, 0);
        chk("rst_quotient", dif.quotient, 0);
        chk("rst_remainder", dif.remainder, 0);
        chk("rst_dbz", dif.div_by_zero, 0);
        chk("rst_ovf", dif.overflow, 0);
        clear = 1'b0;

        seen_busy = 0;
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (dif.busy !== 1'b0) seen_busy++;
            if (dif.done !== 1'b0) seen_done++;
        end
        chk("idle_busy", seen_busy, 0);
        chk("idle_done", seen_done, 0);

        run(16'd100,  8'd7,   8'd14,  8'd2,   1'b0, 1'b0, 8);
        repeat (3) @(negedge clk);
        chk("hold_quotient", dif.quotient, 8'd14);
        chk("hold_remainder", dif.remainder, 8'd2);
        run(16'h1234, 8'h56,  8'h36,  8'h10,  1'b0, 1'b0, 8);
        run(16'hFEFF, 8'hFF,  8'hFF,  8'hFE,  1'b0, 1'b0, 8);
        run(16'h0000, 8'h05,  8'h00,  8'h00,  1'b0, 1'b0, 8);
        run(16'h00AB, 8'h01,  8'hAB,  8'h00,  1'b0, 1'b0, 8);
        run(16'h0100, 8'h01,  8'hFF,  8'h00,  1'b0, 1'b1, 0);
        run(16'h1234, 8'h00,  8'hFF,  8'h00,  1'b1, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("hold_dbz", dif.div_by_zero, 1);
        run(16'd100,  8'd7,   8'd14,  8'd2,   1'b0, 1'b0, 8);

        // Second start mid-run must be ignored.
        issue(16'd100, 8'd7, 1'b1, 8'd14, 8'd2, 1'b0, 1'b0, 8);
        repeat (2) @(posedge clk);
        issue(16'd500, 8'd3, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 0);
        dc = done_cnt;
        wait_done(-1);
        repeat (12) @(posedge clk);
        chk("single_done", done_cnt - dc, 1);

        // Clear in the middle of a run aborts it silently.
        issue(16'h1234, 8'h56, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        dc = done_cnt;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_busy", dif.busy, 0);
        chk("clr_done", dif.done, 0);
        chk("clr_quotient", dif.quotient, 0);
        chk("clr_remainder", dif.remainder, 0);
        chk("clr_dbz", dif.div_by_zero, 0);
        chk("clr_ovf", dif.overflow, 0);
        repeat (12) @(posedge clk);
        chk("clr_no_done", done_cnt - dc, 0);

        run(16'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 8);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
